// File: rtl/pattern_detector_pkg.sv
// Shared constants for the serial pattern detector: FSM encoding and default sizes.
package pattern_detector_pkg;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_ARMED = 2'd2;

  localparam int PAT_LEN_DEF = 8;
  localparam int CNT_W_DEF   = 8;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);
  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr)
      count_d = '0;
    else if (inc && count_q != {WIDTH{1'b1}})
      count_d = count_q + WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;
endmodule

// File: rtl/pattern_detector.sv
// Serial bit-pattern detector: compares the last PAT_LEN accepted bits against a
// runtime-loaded pattern, pulses on a match and keeps a saturating match count.
module pattern_detector
  import pattern_detector_pkg::*;
#(
  parameter int PAT_LEN = PAT_LEN_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_bit_valid,
  input  logic               i_bit_seq,
  input  logic               i_load,
  input  logic [PAT_LEN-1:0] i_pattern,
  input  logic               i_overlap,
  input  logic               i_clear,
  output logic               o_seq_detected,
  output logic [CNT_W-1:0]   o_match_count,
  output logic               o_armed
);
  localparam int FILL_W = $clog2(PAT_LEN + 1);

  logic [1:0]         state_q, state_d;
  logic [PAT_LEN-1:0] pat_q, pat_d;
  logic [PAT_LEN-1:0] shreg_q, shreg_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic               det_q, det_d;
  logic               armed_q, armed_d;

  logic [PAT_LEN-1:0] shifted;
  logic [FILL_W-1:0]  fill_inc;
  logic               hit;

  assign shifted  = {shreg_q[PAT_LEN-2:0], i_bit_seq};
  assign fill_inc = fill_q + FILL_W'(1);

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    shreg_d = shreg_q;
    fill_d  = fill_q;
    armed_d = armed_q;
    hit     = 1'b0;
    if (i_load) begin
      // Load re-arms from scratch; a bit presented alongside it is dropped.
      pat_d   = i_pattern;
      shreg_d = '0;
      fill_d  = '0;
      state_d = ST_FILL;
      armed_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_FILL: if (i_bit_valid) begin
          shreg_d = shifted;
          fill_d  = fill_inc;
          // Only the bit completing the window may match; stale zeros must not.
          if (fill_inc == FILL_W'(PAT_LEN)) begin
            state_d = ST_ARMED;
            hit     = (shifted == pat_q);
          end
        end
        ST_ARMED: if (i_bit_valid) begin
          shreg_d = shifted;
          hit     = (shifted == pat_q);
        end
        default: begin
          state_d = ST_IDLE;
          armed_d = 1'b0;
        end
      endcase
      if (hit && !i_overlap) begin
        fill_d  = '0;
        state_d = ST_FILL;
      end
    end
    det_d = hit;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      pat_q   <= '0;
      shreg_q <= '0;
      fill_q  <= '0;
      det_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      shreg_q <= shreg_d;
      fill_q  <= fill_d;
      det_q   <= det_d;
      armed_q <= armed_d;
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_cnt (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .inc   (hit),
    .clr   (i_clear),
    .count (o_match_count)
  );

  assign o_seq_detected = det_q;
  assign o_armed        = armed_q;
endmodule
